// File: rtl/fp_addsub_pack.sv
// Final FP add/sub stage: exponent adjust, result classification, binary32 pack.
// Two-stage valid/ready pipeline with sticky overflow/underflow/invalid flags.
module fp_addsub_pack #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [EXP_W-1:0]        in_incr,
  input  logic [MANT_W-1:0]       in_mant,
  input  logic                    in_nan,
  input  logic                    in_inf,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W-1:0] out_result,
  input  logic                    flags_clr,
  output logic                    flag_ovf,
  output logic                    flag_unf,
  output logic                    flag_nv
);

  localparam int XW = EXP_W + 2;
  localparam int RW = EXP_W + MANT_W;

  typedef enum logic [2:0] {
    C_NORM, C_NAN, C_INF, C_ZERO, C_OVF, C_UNF
  } cls_e;

  localparam logic signed [XW-1:0] EMAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [XW-1:0] EMIN = '0;

  logic                    s1_valid;
  logic                    s1_sign;
  logic [MANT_W-2:0]       s1_mant;
  logic [EXP_W-1:0]        s1_exp;
  cls_e                    s1_cls;
  cls_e                    s2_cls;
  logic                    s1_en;
  logic                    s2_en;
  logic signed [XW-1:0]    exp_adj;
  cls_e                    cls_d;
  logic [RW-1:0]           pack_d;
  logic                    acc;

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en;
  assign acc      = out_valid && out_ready;

  assign exp_adj = $signed({2'b00, in_exp})
                 + $signed({{2{in_incr[EXP_W-1]}}, in_incr});

  always_comb begin
    cls_d = C_NORM;
    priority case (1'b1)
      in_nan:              cls_d = C_NAN;
      in_inf:              cls_d = C_INF;
      (in_mant == '0):     cls_d = C_ZERO;
      (exp_adj >= EMAX):   cls_d = C_OVF;
      (exp_adj <= EMIN):   cls_d = C_UNF;
      default:             cls_d = C_NORM;
    endcase
  end

  always_comb begin
    pack_d = {s1_sign, s1_exp, s1_mant};
    case (s1_cls)
      C_NAN:   pack_d = {1'b0, {EXP_W{1'b1}}, 1'b1,
                         {(MANT_W-2){1'b0}}};
      C_INF,
      C_OVF:   pack_d = {s1_sign, {EXP_W{1'b1}},
                         {(MANT_W-1){1'b0}}};
      C_ZERO:  pack_d = '0;
      C_UNF:   pack_d = {s1_sign, {(RW-1){1'b0}}};
      default: pack_d = {s1_sign, s1_exp, s1_mant};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mant  <= '0;
      s1_exp   <= '0;
      s1_cls   <= C_NORM;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_sign;
        s1_mant <= in_mant[MANT_W-2:0];
        s1_exp  <= exp_adj[EXP_W-1:0];
        s1_cls  <= cls_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      s2_cls     <= C_NORM;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= pack_d;
        s2_cls     <= s1_cls;
      end
    end
  end

  // Set beats clear when both occur in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_ovf <= 1'b0;
      flag_unf <= 1'b0;
      flag_nv  <= 1'b0;
    end else begin
      flag_ovf <= (flag_ovf && !flags_clr) || (acc && s2_cls == C_OVF);
      flag_unf <= (flag_unf && !flags_clr) || (acc && s2_cls == C_UNF);
      flag_nv  <= (flag_nv  && !flags_clr) || (acc && s2_cls == C_NAN);
    end
  end

endmodule

// File: tb/tb_fp_addsub_pack.sv
// Directed bench for fp_addsub_pack: classes, boundaries, flags,
// backpressure streaming and mid-flight reset.
module tb_fp_addsub_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [7:0]  in_incr;
  logic [23:0] in_mant;
  logic        in_nan;
  logic        in_inf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        flags_clr;
  logic        flag_ovf;
  logic        flag_unf;
  logic        flag_nv;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_addsub_pack dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_incr    (in_incr),
    .in_mant    (in_mant),
    .in_nan     (in_nan),
    .in_inf     (in_inf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .flags_clr  (flags_clr),
    .flag_ovf   (flag_ovf),
    .flag_unf   (flag_unf),
    .flag_nv    (flag_nv)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] e,
                       input logic [7:0] i, input logic [23:0] m,
                       input logic nan, input logic inf);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_incr  = i;
    in_mant  = m;
    in_nan   = nan;
    in_inf   = inf;
  endtask

  // One beat with out_ready=1; called and returns at a negedge.
  task automatic one(input string tag, input logic s,
                     input logic [7:0] e, input logic [7:0] i,
                     input logic [23:0] m, input logic nan,
                     input logic inf, input logic [31:0] res,
                     input logic [2:0] flg);
    out_ready = 1'b1;
    drive(s, e, i, m, nan, inf);
    #1 chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk) in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_result"}, out_result, res);
    @(negedge clk);
    chk({tag, "_flags"}, 32'({flag_ovf, flag_unf, flag_nv}),
        32'(flg));
  endtask

  task automatic clr();
    flags_clr = 1'b1;
    @(negedge clk) flags_clr = 1'b0;
  endtask

  logic [31:0] exp_q[4];
  logic [31:0] held;
  logic        was_stall;
  int          tx;
  int          rx;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_sign = 1'b0;
    in_exp = '0;
    in_incr = '0;
    in_mant = '0;
    in_nan = 1'b0;
    in_inf = 1'b0;
    out_ready = 1'b1;
    flags_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", out_result, 32'h0);
    chk("rst_flags", 32'({flag_ovf, flag_unf, flag_nv}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    one("norm", 1'b0, 8'd127, 8'h01, 24'hC00000, 0, 0,
        32'h40400000, 3'b000);
    chk("norm_drain", 32'(out_valid), 32'd0);
    one("ovf", 1'b1, 8'd254, 8'h01, 24'h800000, 0, 0,
        32'hFF800000, 3'b100);
    clr();
    one("unf", 1'b0, 8'd3, 8'hFB, 24'h800000, 0, 0,
        32'h00000000, 3'b010);
    clr();
    one("zero", 1'b1, 8'd3, 8'hFB, 24'h000000, 0, 0,
        32'h00000000, 3'b000);
    one("unf_neg", 1'b1, 8'd1, 8'hFF, 24'h800000, 0, 0,
        32'h80000000, 3'b010);
    clr();
    one("max_norm", 1'b0, 8'd253, 8'h01, 24'hFFFFFF, 0, 0,
        32'h7F7FFFFF, 3'b000);
    one("min_norm", 1'b0, 8'd2, 8'hFF, 24'h800000, 0, 0,
        32'h00800000, 3'b000);
    one("inf", 1'b1, 8'd10, 8'h00, 24'h800000, 0, 1,
        32'hFF800000, 3'b000);
    one("nan", 1'b1, 8'd10, 8'h00, 24'h800000, 1, 1,
        32'h7FC00000, 3'b001);
    clr();
    chk("clr_flags", 32'({flag_ovf, flag_unf, flag_nv}), 32'd0);

    // clear coinciding with a NaN accept: set must win
    drive(1'b0, 8'd5, 8'h00, 24'h800000, 1'b1, 1'b0);
    @(negedge clk) in_valid = 1'b0;
    @(negedge clk) flags_clr = 1'b1;
    @(negedge clk) flags_clr = 1'b0;
    chk("clr_vs_set", 32'(flag_nv), 32'd1);
    clr();

    // backpressure stream
    for (int k = 0; k < 4; k++)
      exp_q[k] = {1'b0, 8'(100 + k), 23'(k)};
    tx = 0;
    rx = 0;
    was_stall = 1'b0;
    held = '0;
    for (int c = 0; c < 30 && rx < 4; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (tx < 4)
        drive(1'b0, 8'(100 + tx), 8'h00, 24'h800000 | 24'(tx), 0, 0);
      else
        in_valid = 1'b0;
      #1;
      if (c == 3)
        chk("stall_in_ready", 32'(in_ready), 32'd0);
      if (was_stall)
        chk("stall_hold", out_result, held);
      if (out_valid && out_ready) begin
        chk($sformatf("stream_%0d", rx), out_result, exp_q[rx]);
        rx++;
      end
      if (in_valid && in_ready)
        tx++;
      was_stall = out_valid && !out_ready;
      held = out_result;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("stream_count", 32'(rx), 32'd4);
    @(negedge clk);
    chk("stream_no_dup", 32'(out_valid), 32'd0);

    // mid-flight reset with a sticky flag set
    one("pre_rst", 1'b0, 8'd255, 8'h00, 24'h800000, 0, 0,
        32'h7F800000, 3'b100);
    out_ready = 1'b0;
    drive(1'b0, 8'd120, 8'h00, 24'h800000, 0, 0);
    @(negedge clk);
    drive(1'b0, 8'd121, 8'h00, 24'h800000, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_flags", 32'({flag_ovf, flag_unf, flag_nv}), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("mid_rst_drop", 32'(out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
